lane_merge_rx: RTL and testbench

- Receive-side counterpart of the class router/serializer (device1).
- Takes its two serial lanes, deserializes 10-bit words MSB-first, and checks each word's class bit against its lane.
- Buffers each lane in a small FIFO, then round-robin merges both lanes into one parallel 10-bit stream with a valid/ready handshake.
- Sits at the far end of the lane pair, feeding the parallel consumer; reports class, framing and overflow errors.

---
 rtl/lane_merge_pkg.sv | 17 +
 rtl/lane_merge_rx_if.sv | 25 ++
 rtl/lane_deser_fifo.sv | 88 ++++++++
 rtl/lane_merge_rx.sv | 67 ++++++
 tb/tb_lane_merge_rx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_merge_pkg.sv
// Shared constants and helpers for the two-lane serial receiver/merger.
package lane_merge_pkg;
    localparam int DATA_SIZE     = 10;
    localparam int FIFO_DEPTH    = 4;
    localparam int PTR_SIZE      = 2;
    localparam int CLASS_BIT     = 9;
    localparam int ROUTE_BIT     = 8;
    localparam int BITS_PER_WORD = 10;
    localparam logic LANE0_CLASS = 1'b0;
    localparam logic LANE1_CLASS = 1'b1;

    typedef logic [DATA_SIZE-1:0] word_t;

    function automatic logic class_ok(input word_t w, input logic exp_class);
        return w[CLASS_BIT] == exp_class;
    endfunction
endpackage

// File: rtl/lane_merge_rx_if.sv
// Bundle of the serial lane inputs, merged output handshake and error pulses.
interface lane_merge_rx_if;
    import lane_merge_pkg::*;

    logic        in0_bit;
    logic        in0_valid;
    logic        in1_bit;
    logic        in1_valid;
    word_t       out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  err_class;
    logic [1:0]  err_frame;
    logic [1:0]  err_ovf;

    modport master (
        output in0_bit, in0_valid, in1_bit, in1_valid, out_ready,
        input  out_data, out_valid, err_class, err_frame, err_ovf
    );

    modport slave (
        input  in0_bit, in0_valid, in1_bit, in1_valid, out_ready,
        output out_data, out_valid, err_class, err_frame, err_ovf
    );
endinterface

// File: rtl/lane_deser_fifo.sv
// One receive lane: MSB-first deserializer, class check, small FIFO and error pulses.
// With CLASS_DROP_EN defined, words failing the class check are not pushed.
module lane_deser_fifo
    import lane_merge_pkg::*;
#(
    parameter logic EXP_CLASS = 1'b0
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  in_bit,
    input  logic  in_valid,
    input  logic  pop,
    output word_t head,
    output logic  not_empty,
    output logic  err_class,
    output logic  err_frame,
    output logic  err_ovf
);
    localparam logic [3:0]        LAST_BIT = 4'(BITS_PER_WORD - 1);
    localparam logic [PTR_SIZE:0] FULL_CNT = (PTR_SIZE + 1)'(FIFO_DEPTH);

    logic [3:0]           cnt_reg;
    logic [DATA_SIZE-2:0] sh_reg;
    word_t                mem [FIFO_DEPTH];
    logic [PTR_SIZE-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_SIZE:0]    count_reg;
    logic                 err_class_reg, err_frame_reg, err_ovf_reg;

    word_t word_done;
    logic  complete, class_bad, push_req, full, do_pop, do_push;

    always_comb begin
        word_done = {sh_reg, in_bit};
        complete  = in_valid && (cnt_reg == LAST_BIT);
        class_bad = complete && !class_ok(word_done, EXP_CLASS);
`ifdef CLASS_DROP_EN
        push_req  = complete && !class_bad;
`else
        push_req  = complete;
`endif
        full      = (count_reg == FULL_CNT);
        do_pop    = pop && (count_reg != '0);
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        do_push   = push_req && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg       <= '0;
            sh_reg        <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_class_reg <= 1'b0;
            err_frame_reg <= 1'b0;
            err_ovf_reg   <= 1'b0;
        end else begin
            if (in_valid) begin
                sh_reg  <= word_done[DATA_SIZE-2:0];
                cnt_reg <= complete ? 4'd0 : cnt_reg + 4'd1;
            end else begin
                cnt_reg <= 4'd0;
            end
            err_class_reg <= class_bad;
            err_frame_reg <= !in_valid && (cnt_reg != 4'd0);
            err_ovf_reg   <= push_req && !do_push;
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; the head is read combinationally so a word
    // can reach the output register one edge after it completes.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= word_done;
    end

    assign head      = mem[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign err_class = err_class_reg;
    assign err_frame = err_frame_reg;
    assign err_ovf   = err_ovf_reg;
endmodule

// File: rtl/lane_merge_rx.sv
// Two-lane serial receiver merging both lane FIFOs round-robin into one stream.
// CLASS_DROP_EN (optional) discards misclassified words inside each lane.
module lane_merge_rx
    import lane_merge_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    lane_merge_rx_if.slave bus
);
    logic [1:0] lane_bit, lane_valid, pop, not_empty;
    logic [1:0] e_class, e_frame, e_ovf;
    word_t      head [2];

    word_t      out_data_reg;
    logic       out_valid_reg;
    logic       last_grant_reg;
    logic       load, grant;

    assign lane_bit   = {bus.in1_bit,   bus.in0_bit};
    assign lane_valid = {bus.in1_valid, bus.in0_valid};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            lane_deser_fifo #(
                .EXP_CLASS (gi == 0 ? LANE0_CLASS : LANE1_CLASS)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .in_bit    (lane_bit[gi]),
                .in_valid  (lane_valid[gi]),
                .pop       (pop[gi]),
                .head      (head[gi]),
                .not_empty (not_empty[gi]),
                .err_class (e_class[gi]),
                .err_frame (e_frame[gi]),
                .err_ovf   (e_ovf[gi])
            );
        end
    endgenerate

    // On a tie the lane that did not win last time is served.
    always_comb begin
        load  = (!out_valid_reg || bus.out_ready) && (|not_empty);
        grant = (&not_empty) ? !last_grant_reg : not_empty[1];
        pop   = load ? {grant, !grant} : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (load) begin
            out_data_reg   <= head[grant];
            out_valid_reg  <= 1'b1;
            last_grant_reg <= grant;
        end else if (bus.out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.err_class = e_class;
    assign bus.err_frame = e_frame;
    assign bus.err_ovf   = e_ovf;
endmodule

// File: tb/tb_lane_merge_rx.sv
// Bench for lane_merge_rx: vector table, directed corner sequences and random
// traffic against a queue-level reference model. Honours CLASS_DROP_EN.
module tb_lane_merge_rx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    lane_merge_rx_if bus ();

    lane_merge_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef CLASS_DROP_EN
    localparam bit OUT_ON_BAD = 1'b0;
`else
    localparam bit OUT_ON_BAD = 1'b1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words accumulate arithmetically; each lane buffer is a
    // plain array kept packed at index 0; one output slot.
    int         m_acc [2];
    int         m_n   [2];
    logic [9:0] m_fifo [2][4];
    int         m_cnt [2];
    logic       m_ov;
    logic [9:0] m_od;
    int         m_last;
    logic [1:0] m_ec, m_ef, m_eo;

    task automatic model_step(input logic rst_n, input logic [1:0] b, input logic [1:0] v,
                              input logic rdy);
        int g;
        logic [9:0] w;
        logic bad;
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                m_acc[l] = 0; m_n[l] = 0; m_cnt[l] = 0;
            end
            m_ov = 1'b0; m_od = '0; m_last = 1;
            m_ec = '0; m_ef = '0; m_eo = '0;
            return;
        end
        m_ec = '0; m_ef = '0; m_eo = '0;
        if (!m_ov || rdy) begin
            g = -1;
            if (m_cnt[0] > 0 && m_cnt[1] > 0) g = 1 - m_last;
            else if (m_cnt[0] > 0)            g = 0;
            else if (m_cnt[1] > 0)            g = 1;
            if (g >= 0) begin
                m_od = m_fifo[g][0];
                for (int j = 0; j < 3; j++) m_fifo[g][j] = m_fifo[g][j+1];
                m_cnt[g]--;
                m_ov = 1'b1;
                m_last = g;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (v[l]) begin
                m_acc[l] = m_acc[l] * 2 + int'(b[l]);
                m_n[l]++;
                if (m_n[l] == 10) begin
                    w = m_acc[l][9:0];
                    m_acc[l] = 0; m_n[l] = 0;
                    bad = (w[9] != (l == 1));
                    if (bad) m_ec[l] = 1'b1;
`ifdef CLASS_DROP_EN
                    if (!bad) begin
`else
                    begin
`endif
                        if (m_cnt[l] < 4) begin
                            m_fifo[l][m_cnt[l]] = w;
                            m_cnt[l]++;
                        end else begin
                            m_eo[l] = 1'b1;
                        end
                    end
                end
            end else if (m_n[l] != 0) begin
                m_ef[l] = 1'b1;
                m_n[l] = 0; m_acc[l] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(reset, {bus.in1_bit, bus.in0_bit}, {bus.in1_valid, bus.in0_valid},
                   bus.out_ready);
        mon_en = 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) chk("mon_out_data", 32'(bus.out_data), 32'(m_od));
            chk("mon_err_class", 32'(bus.err_class), 32'(m_ec));
            chk("mon_err_frame", 32'(bus.err_frame), 32'(m_ef));
            chk("mon_err_ovf",   32'(bus.err_ovf),   32'(m_eo));
        end
    end

    task automatic set_lane(input int lane, input logic b, input logic v);
        if (lane == 0) begin bus.in0_bit = b; bus.in0_valid = v; end
        else           begin bus.in1_bit = b; bus.in1_valid = v; end
    endtask

    // Returns at the falling edge right after the edge that sampled the last bit.
    task automatic send_word(input int lane, input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk); set_lane(lane, w[i], 1'b1);
        end
        @(negedge clk); set_lane(lane, 1'b0, 1'b0);
    endtask

    task automatic send_pair(input logic [9:0] w0, input logic [9:0] w1);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk); set_lane(0, w0[i], 1'b1); set_lane(1, w1[i], 1'b1);
        end
        @(negedge clk); set_lane(0, 1'b0, 1'b0); set_lane(1, 1'b0, 1'b0);
    endtask

    typedef struct {
        int         lane;
        logic [9:0] word;
        logic [9:0] exp_data;
        logic [1:0] exp_class;
        logic       exp_out;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, 10'h0FF, 10'h0FF, 2'b00, 1'b1};
        vecs[1] = '{1, 10'h3DD, 10'h3DD, 2'b00, 1'b1};
        vecs[2] = '{0, 10'h3CC, 10'h3CC, 2'b01, OUT_ON_BAD};
        vecs[3] = '{1, 10'h155, 10'h155, 2'b10, OUT_ON_BAD};
        vecs[4] = '{0, 10'h000, 10'h000, 2'b00, 1'b1};
        vecs[5] = '{1, 10'h3FF, 10'h3FF, 2'b00, 1'b1};

        bus.in0_bit = 0; bus.in0_valid = 0; bus.in1_bit = 0; bus.in1_valid = 0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_err", 32'({bus.err_class, bus.err_frame, bus.err_ovf}), 32'd0);
        reset = 1'b1;

        // Single words from the table
        foreach (vecs[i]) begin
            send_word(vecs[i].lane, vecs[i].word);
            chk("vec_err_class", 32'(bus.err_class), 32'(vecs[i].exp_class));
            @(negedge clk);
            chk("vec_out_valid", 32'(bus.out_valid), 32'(vecs[i].exp_out));
            if (vecs[i].exp_out) chk("vec_out_data", 32'(bus.out_data), 32'(vecs[i].exp_data));
            @(negedge clk);
            chk("vec_out_idle", 32'(bus.out_valid), 32'd0);
        end

        // Simultaneous completion right after reset: lane 0 first
        reset = 1'b0; repeat (2) @(negedge clk); reset = 1'b1;
        send_pair(10'h0EE, 10'h3DD);
        @(negedge clk);
        chk("tie_first",  32'(bus.out_data), 32'h0EE);
        @(negedge clk);
        chk("tie_second", 32'(bus.out_data), 32'h3DD);
        chk("tie_valid",  32'(bus.out_valid), 32'd1);
        @(negedge clk);
        chk("tie_idle",   32'(bus.out_valid), 32'd0);

        // Back-pressure: 1 held + 4 buffered, 6th word overflows
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_word(0, 10'h0AA + 10'(i));
        chk("ovf_pulse", 32'(bus.err_ovf), 32'b01);
        chk("ovf_hold",  32'(bus.out_data), 32'h0AA);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("ovf_drain", 32'(bus.out_data), 32'h0AA + 32'(i));
        end
        @(negedge clk);
        chk("ovf_empty", 32'(bus.out_valid), 32'd0);

        // Framing error on lane 1, then a clean aligned word
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk); set_lane(1, i[0], 1'b1);
        end
        @(negedge clk); set_lane(1, 1'b0, 1'b0);
        @(negedge clk);
        chk("frame_pulse", 32'(bus.err_frame), 32'b10);
        chk("frame_noout", 32'(bus.out_valid), 32'd0);
        send_word(1, 10'h399);
        @(negedge clk);
        chk("frame_realign", 32'(bus.out_data), 32'h399);

        // Reset mid-word while an output word is held
        bus.out_ready = 1'b0;
        send_word(0, 10'h0AA);
        @(negedge clk);
        chk("mrst_held", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_lane(0, i[0], 1'b1);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; set_lane(0, 1'b0, 1'b0);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_data",  32'(bus.out_data),  32'd0);
        bus.out_ready = 1'b1;
        send_word(0, 10'h0BB);
        @(negedge clk);
        chk("mrst_clean", 32'(bus.out_data), 32'h0BB);

        // Random traffic with back-pressure bursts, checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.in0_valid = ($urandom_range(0, 49) != 0);
            bus.in0_bit   = 1'($urandom_range(0, 1));
            bus.in1_valid = ($urandom_range(0, 49) != 0);
            bus.in1_bit   = 1'($urandom_range(0, 1));
            bus.out_ready = ((c % 200) < 50) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        set_lane(0, 1'b0, 1'b0); set_lane(1, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("final_idle", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
